// File: rtl/motoro3_gate_deadtime.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module : motoro3_gate_deadtime                                         |
// | Brief  : Six-gate driver for the 3-phase PWM stage. Inserts dead-time  |
// |          on commutation, stretches short high-side pulses to MIN_ON,   |
// |          and latches a synchronised over-current fault until cleared.  |
// | Rev    : 1.0  initial release                                          |
// +------------------------------------------------------------------------+
module motoro3_gate_deadtime #(
  parameter int unsigned DEAD_CYC = 8,
  parameter int unsigned MIN_ON   = 32
) (
  input  logic       clk,
  input  logic       nRst,
  input  logic       enable,
  input  logic [3:0] sgStep,
  input  logic       pwm,
  input  logic       m3cntLast2,
  input  logic       fault,
  input  logic       clrFault,
  output logic       gateAH,
  output logic       gateAL,
  output logic       gateBH,
  output logic       gateBL,
  output logic       gateCH,
  output logic       gateCL,
  output logic       deadActive,
  output logic       faultLatched,
  output logic [7:0] stretchCnt
);

  typedef enum logic [1:0] {
    ST_OFF   = 2'd0,
    ST_DEAD  = 2'd1,
    ST_RUN   = 2'd2,
    ST_FAULT = 2'd3
  } state_t;

  localparam logic [7:0] DEAD_LOAD = 8'(DEAD_CYC);
  localparam logic [7:0] ON_LOAD   = 8'(MIN_ON - 1);

  // Gate vector bit order: {AH, AL, BH, BL, CH, CL}
  function automatic logic [5:0] sector_drive(input logic [2:0] sector, input logic hi_on);
    logic [5:0] pat;
    pat = '0;
    case (sector)
      3'd0: begin pat[5] = hi_on; pat[0] = 1'b1; end  // AH, CL
      3'd1: begin pat[3] = hi_on; pat[0] = 1'b1; end  // BH, CL
      3'd2: begin pat[3] = hi_on; pat[4] = 1'b1; end  // BH, AL
      3'd3: begin pat[1] = hi_on; pat[4] = 1'b1; end  // CH, AL
      3'd4: begin pat[1] = hi_on; pat[2] = 1'b1; end  // CH, BL
      3'd5: begin pat[5] = hi_on; pat[2] = 1'b1; end  // AH, BL
      default: pat = '0;
    endcase
    return pat;
  endfunction

  state_t     state_q, state_d;
  logic [7:0] dead_cnt_q, dead_cnt_d;
  logic [7:0] on_cnt_q, on_cnt_d;
  logic [2:0] cur_sector_q, cur_sector_d;
  logic       hi_q, hi_d;
  logic [5:0] gate_q, gate_d;
  logic       dead_active_q, dead_active_d;
  logic       fault_latched_q, fault_latched_d;
  logic [7:0] stretch_cnt_q, stretch_cnt_d;
  logic       fault_meta_q, fault_meta_d;
  logic       fault_sync_q, fault_sync_d;

  logic       step_valid;
  logic [2:0] step_sector;
  logic       run_drive;
  logic       stretch_inc;

  assign step_valid  = (sgStep < 4'd12);
  assign step_sector = sgStep[3:1];

  // Next-state, gate pattern, min-on stretch and stretch statistics
  always_comb begin
    state_d         = state_q;
    dead_cnt_d      = dead_cnt_q;
    on_cnt_d        = 8'd0;
    cur_sector_d    = cur_sector_q;
    hi_d            = 1'b0;
    run_drive       = 1'b0;
    stretch_inc     = 1'b0;
    fault_meta_d    = fault;
    fault_sync_d    = fault_meta_q;

    // Fault beats everything; FAULT is sticky until an accepted clear.
    if (fault_sync_q) begin
      state_d = ST_FAULT;
    end else if (state_q == ST_FAULT) begin
      if (clrFault) state_d = ST_OFF;
    end else if (!enable) begin
      state_d = ST_OFF;
    end else begin
      unique case (state_q)
        ST_OFF: begin
          if (step_valid) begin
            state_d    = ST_DEAD;
            dead_cnt_d = DEAD_LOAD;
          end
        end
        ST_DEAD: begin
          if (dead_cnt_q == 8'd1) begin
            if (step_valid) begin
              state_d      = ST_RUN;
              cur_sector_d = step_sector;
              run_drive    = 1'b1;
            end else begin
              state_d = ST_OFF;
            end
          end else begin
            dead_cnt_d = dead_cnt_q - 8'd1;
          end
        end
        ST_RUN: begin
          // A step change inside the same sector is not a commutation.
          if (!step_valid || (step_sector != cur_sector_q)) begin
            state_d    = ST_DEAD;
            dead_cnt_d = DEAD_LOAD;
          end else begin
            run_drive = 1'b1;
          end
        end
        ST_FAULT: state_d = ST_FAULT;
      endcase
    end

    // High side follows pwm but is held on until MIN_ON cycles have elapsed.
    if (run_drive) begin
      hi_d = pwm | (on_cnt_q != 8'd0);
      if (hi_d && !hi_q) begin
        on_cnt_d = ON_LOAD;
      end else if (on_cnt_q != 8'd0) begin
        on_cnt_d = on_cnt_q - 8'd1;
      end
      stretch_inc = !pwm && (on_cnt_q == 8'd1);
    end

    gate_d          = run_drive ? sector_drive(cur_sector_d, hi_d) : 6'd0;
    dead_active_d   = (state_d == ST_DEAD);
    fault_latched_d = (state_d == ST_FAULT);

    if (m3cntLast2) begin
      stretch_cnt_d = 8'd0;
    end else if (stretch_inc && (stretch_cnt_q != 8'hFF)) begin
      stretch_cnt_d = stretch_cnt_q + 8'd1;
    end else begin
      stretch_cnt_d = stretch_cnt_q;
    end
  end

  // All state updates on the falling edge, asynchronous active-low reset
  always_ff @(negedge clk or negedge nRst) begin
    if (!nRst) begin
      state_q         <= ST_OFF;
      dead_cnt_q      <= 8'd0;
      on_cnt_q        <= 8'd0;
      cur_sector_q    <= 3'd0;
      hi_q            <= 1'b0;
      gate_q          <= 6'd0;
      dead_active_q   <= 1'b0;
      fault_latched_q <= 1'b0;
      stretch_cnt_q   <= 8'd0;
      fault_meta_q    <= 1'b0;
      fault_sync_q    <= 1'b0;
    end else begin
      state_q         <= state_d;
      dead_cnt_q      <= dead_cnt_d;
      on_cnt_q        <= on_cnt_d;
      cur_sector_q    <= cur_sector_d;
      hi_q            <= hi_d;
      gate_q          <= gate_d;
      dead_active_q   <= dead_active_d;
      fault_latched_q <= fault_latched_d;
      stretch_cnt_q   <= stretch_cnt_d;
      fault_meta_q    <= fault_meta_d;
      fault_sync_q    <= fault_sync_d;
    end
  end

  assign gateAH       = gate_q[5];
  assign gateAL       = gate_q[4];
  assign gateBH       = gate_q[3];
  assign gateBL       = gate_q[2];
  assign gateCH       = gate_q[1];
  assign gateCL       = gate_q[0];
  assign deadActive   = dead_active_q;
  assign faultLatched = fault_latched_q;
  assign stretchCnt   = stretch_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_motoro3_gate_deadtime.sv
`default_nettype none
`timescale 1ns/1ps
// +------------------------------------------------------------------------+
// | Module : tb_motoro3_gate_deadtime                                      |
// | Brief  : Bench for motoro3_gate_deadtime with a timestamp-based model  |
// | Rev    : 1.0  initial release                                          |
// +------------------------------------------------------------------------+
module tb_motoro3_gate_deadtime;

  localparam int DEAD_CYC = 8;
  localparam int MIN_ON   = 32;
  localparam int M_OFF = 0, M_DEAD = 1, M_RUN = 2, M_FLT = 3;

  logic       clk = 1'b1;
  logic       nRst, enable, pwm, m3cntLast2, fault, clrFault;
  logic [3:0] sgStep;
  wire        gateAH, gateAL, gateBH, gateBL, gateCH, gateCL;
  wire        deadActive, faultLatched;
  wire  [7:0] stretchCnt;
  wire  [5:0] g_dut = {gateAH, gateAL, gateBH, gateBL, gateCH, gateCL};

  int checks = 0;
  int passes = 0;
  bit cmp_en = 1'b0;

  motoro3_gate_deadtime #(.DEAD_CYC(DEAD_CYC), .MIN_ON(MIN_ON)) dut (
    .clk(clk), .nRst(nRst), .enable(enable), .sgStep(sgStep), .pwm(pwm),
    .m3cntLast2(m3cntLast2), .fault(fault), .clrFault(clrFault),
    .gateAH(gateAH), .gateAL(gateAL), .gateBH(gateBH), .gateBL(gateBL),
    .gateCH(gateCH), .gateCL(gateCL), .deadActive(deadActive),
    .faultLatched(faultLatched), .stretchCnt(stretchCnt)
  );

  always #50 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model (edge count + timestamps) ----------
  int m_mode, m_cyc, m_dead_start, m_on_start, m_sector, m_stretch;
  bit m_hi, m_f1, m_f2;

  task automatic model_reset();
    m_mode = M_OFF; m_cyc = 0; m_dead_start = 0; m_on_start = 0;
    m_sector = 0; m_stretch = 0; m_hi = 0; m_f1 = 0; m_f2 = 0;
  endtask

  task automatic model_step();
    bit fs, valid, drive, hi, inc, held;
    int sec;
    fs = m_f2; m_f2 = m_f1; m_f1 = fault; m_cyc++;
    valid = (sgStep < 4'd12);
    sec = int'(sgStep) / 2;
    drive = 0; hi = 0; inc = 0;
    if (fs) m_mode = M_FLT;
    else if (m_mode == M_FLT) begin
      if (clrFault) m_mode = M_OFF;
    end else if (!enable) m_mode = M_OFF;
    else begin
      case (m_mode)
        M_OFF: if (valid) begin m_mode = M_DEAD; m_dead_start = m_cyc; end
        M_DEAD: if (m_cyc - m_dead_start >= DEAD_CYC) begin
          if (valid) begin m_mode = M_RUN; m_sector = sec; drive = 1; end
          else m_mode = M_OFF;
        end
        M_RUN: if (!valid || sec != m_sector) begin m_mode = M_DEAD; m_dead_start = m_cyc; end
               else drive = 1;
        default: ;
      endcase
    end
    if (drive) begin
      held = m_hi && (m_cyc - m_on_start < MIN_ON);
      hi   = pwm || held;
      inc  = !pwm && m_hi && (m_cyc - m_on_start == MIN_ON - 1);
      if (hi && !m_hi) m_on_start = m_cyc;
    end
    m_hi = hi;
    if (m3cntLast2) m_stretch = 0;
    else if (inc && m_stretch < 255) m_stretch++;
  endtask

  function automatic logic [5:0] exp_gates();
    logic [5:0] v;
    int src_ph[6] = '{0, 1, 1, 2, 2, 0};
    int snk_ph[6] = '{2, 2, 0, 0, 1, 1};
    v = '0;
    if (m_mode == M_RUN) begin
      v[4 - 2 * snk_ph[m_sector]] = 1'b1;
      if (m_hi) v[5 - 2 * src_ph[m_sector]] = 1'b1;
    end
    return v;
  endfunction

  initial begin
    model_reset();
    forever begin
      @(negedge clk or negedge nRst);
      if (!nRst) model_reset();
      else model_step();
    end
  end

  // ---------------- per-cycle comparison -----------------------------------
  int         zero_run = 0;
  logic [5:0] prev_lo  = '0;

  initial begin
    forever begin
      @(posedge clk);
      if (cmp_en) begin
        check("outputs", {g_dut, deadActive, faultLatched, stretchCnt},
              {exp_gates(), m_mode == M_DEAD, m_mode == M_FLT, m_stretch[7:0]});
        check("no_shoot_through",
              {31'd0, (gateAH & gateAL) | (gateBH & gateBL) | (gateCH & gateCL)}, 32'd0);
        if (g_dut == 6'd0) zero_run++;
        else begin
          if (zero_run > 0) check("dead_before_run", zero_run >= DEAD_CYC, 1);
          else              check("low_side_stable", g_dut & 6'b010101, prev_lo);
          prev_lo  = g_dut & 6'b010101;
          zero_run = 0;
        end
      end
    end
  end

  // ---------------- stimulus helpers ---------------------------------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic wait_run(input int max_cyc, output int dead_seen, output bit ok);
    dead_seen = 0; ok = 0;
    for (int k = 0; k < max_cyc; k++) begin
      @(posedge clk);
      if (deadActive) dead_seen++;
      if (g_dut != 6'd0) begin ok = 1; break; end
    end
  endtask

  task automatic pulse(input int len, input int window, input int sel, output int hi_cnt);
    hi_cnt = 0;
    pwm = 1'b1;
    for (int k = 1; k <= window; k++) begin
      @(posedge clk);
      if (g_dut[sel]) hi_cnt++;
      if (k == len) pwm = 1'b0;
    end
  endtask

  initial begin
    #20ms;
    $display("FAIL timeout actual=running required=finished");
    $display("%0d/%0d checks passed", passes, checks + 1);
    $fatal(1, "bench timeout");
  end

  // ---------------- directed + random sequence -----------------------------
  initial begin
    int dc, hc, cnt;
    bit ok;
    nRst = 0; enable = 0; sgStep = 0; pwm = 0; m3cntLast2 = 0; fault = 0; clrFault = 0;
    tick(2);
    cmp_en = 1'b1;
    tick(2);
    check("reset_outputs", {g_dut, deadActive, faultLatched, stretchCnt}, 0);

    // 1: startup dead-time, then sector 0, long pulse passes unchanged
    nRst = 1; enable = 1; sgStep = 0;
    wait_run(40, dc, ok);
    check("t1_reached_run", ok, 1);
    check("t1_dead_cycles", dc, 8);
    check("t1_sector0_idle", g_dut, 6'b000001);
    pulse(100, 130, 5, hc);
    check("t1_pulse_len", hc, 100);
    check("t1_stretch_zero", stretchCnt, 0);

    // 2: one-cycle pulse stretched to MIN_ON; period strobe clears count
    pulse(1, 50, 5, hc);
    check("t2_stretched_len", hc, 32);
    check("t2_stretch_one", stretchCnt, 1);
    m3cntLast2 = 1; tick(1); m3cntLast2 = 0; tick(1);
    check("t2_stretch_cleared", stretchCnt, 0);

    // 3: in-sector step change, then commutation mid-stretch
    sgStep = 1;
    cnt = 0;
    for (int k = 0; k < 12; k++) begin tick(1); if (deadActive || !gateCL) cnt++; end
    check("t3_no_dead_in_sector", cnt, 0);
    pwm = 1; tick(1); pwm = 0; tick(5);
    check("t3_midstretch", gateAH, 1);
    sgStep = 4;
    wait_run(40, dc, ok);
    check("t3_commutation_dead", dc, 8);
    check("t3_sector2_idle", g_dut, 6'b010000);
    pulse(40, 60, 3, hc);
    check("t3_bh_pulse_len", hc, 40);

    // 4: fault latency, ignored clear, accepted clear
    fault = 1;
    tick(1); check("t4_edge1_live", g_dut != 0, 1);
    tick(1); check("t4_edge2_live", g_dut != 0, 1);
    tick(1); check("t4_edge3_off", g_dut, 0);
    check("t4_fault_latched", faultLatched, 1);
    clrFault = 1; tick(5);
    check("t4_clear_ignored", faultLatched, 1);
    fault = 0;
    wait_run(40, dc, ok);
    clrFault = 0;
    check("t4_recover_dead", dc, 8);
    check("t4_recover_pattern", {faultLatched, g_dut}, 7'b0010000);

    // 5: all-off step, enable drop mid-pulse, async reset mid-run
    sgStep = 12;
    cnt = 0;
    for (int k = 0; k < 20; k++) begin tick(1); if (deadActive) cnt++; end
    check("t5_alloff_dead", cnt, 8);
    check("t5_alloff_state", {g_dut, deadActive}, 0);
    sgStep = 0;
    wait_run(40, dc, ok);
    check("t5_restart_dead", dc, 8);
    pwm = 1; tick(3);
    check("t5_gate_on", gateAH, 1);
    enable = 0; tick(1);
    check("t5_enable_off", g_dut, 0);
    pwm = 0; enable = 1;
    wait_run(40, dc, ok);
    check("t5_reenable_dead", dc, 8);
    pwm = 1; tick(2);
    #20 nRst = 0;
    #1 check("t5_async_reset", {g_dut, deadActive, faultLatched, stretchCnt}, 0);
    tick(2);
    nRst = 1; pwm = 0;

    // 6a: random traffic, checked every cycle by the model
    for (int k = 0; k < 12000; k++) begin
      tick(1);
      if ($urandom_range(0, 9) == 0) pwm = ~pwm;
      if ($urandom_range(0, 199) == 0) sgStep = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 399) == 0) enable = ~enable;
      if (!enable && $urandom_range(0, 19) == 0) enable = 1;
      if ($urandom_range(0, 999) == 0) fault = 1;
      else if (fault && $urandom_range(0, 9) == 0) fault = 0;
      clrFault   = ($urandom_range(0, 49) == 0);
      m3cntLast2 = ($urandom_range(0, 299) == 0);
    end

    // 6b: 300 short pulses without a period strobe saturate the counter
    fault = 0; clrFault = 1; enable = 1; sgStep = 0; pwm = 0; m3cntLast2 = 0;
    tick(5); clrFault = 0;
    wait_run(40, dc, ok);
    check("t6_reached_run", ok, 1);
    m3cntLast2 = 1; tick(1); m3cntLast2 = 0;
    for (int p = 0; p < 300; p++) begin
      pulse($urandom_range(1, 20), 40, 5, hc);
      if (p == 99) check("t6_stretch_100", stretchCnt, 100);
    end
    check("t6_stretch_saturated", stretchCnt, 255);

    tick(2);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
`default_nettype wire
